vit_io_stager: RTL and testbench
================================

# vit_io_stager

Host-facing staging block for the ViT encoder datapath: accepts multi-lane host writes into a double-buffered activation (X) store and a single weight-word (W) staging store, commits them atomically to the compute blocks, and serialises the feed-forward result back to the host with valid/ready backpressure. It replaces the single-word, fixed-address load path and the free-running output shifter at the top level. Each lane is one DATA_WIDTH word.

## Interface
- DATA_WIDTH, 4, bits per word
- LANES, 2, words per host beat (≥1)
- X_WORDS, 768, X buffer depth in words (QKV*H)
- W_WORDS, 64, W staging depth in words (ROWS*MACS*PES)
- OUT_WORDS, 768, result vector length in words
- ADDR_W, $clog2(max(X_WORDS,W_WORDS))+1, word-pointer width

- clk  in  1  clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- in_valid  in  1  host beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*DATA_WIDTH  lane 0 in LSBs
- in_sel  in  1  0 = W store, 1 = X store
- in_addr_set  in  1  load write pointer from in_addr
- in_addr  in  ADDR_W  new write pointer (word index)
- in_last  in  1  final beat of a load; triggers commit
- x_active  out  X_WORDS*DATA_WIDTH  committed X vector to QKV/FF blocks
- w_active  out  W_WORDS*DATA_WIDTH  committed weight word to memory write port
- x_commit, w_commit  out  1  one-cycle pulse when respective store committed
- in_ovf  out  1  sticky: a lane addressed beyond store depth was dropped
- res_valid  in  1  FF result available (FF output_rdy)
- res_data  in  OUT_WORDS*DATA_WIDTH  FF result
- res_ack  out  1  one-cycle acknowledge to FF block
- out_valid  out  1  output beat valid
- out_ready  in  1  host accepts output beat
- out_data  out  LANES*DATA_WIDTH  output beat, lane 0 = lowest word index
- out_last  out  1  final output beat

## Operation
- Input FSM: I_ACCEPT, I_COMMIT. in_ready = 1 in I_ACCEPT only.
- Accepted beat (in_valid && in_ready): lane k written to shadow store selected by in_sel at wr_ptr+k; wr_ptr += LANES. Lanes with index ≥ store depth dropped and set in_ovf.
- in_addr_set in I_ACCEPT: wr_ptr ← in_addr; if same cycle as accepted beat, beat is written starting at in_addr, then wr_ptr = in_addr+LANES. in_addr_set also clears in_ovf (set-wins if that beat overflows).
- in_last on accepted beat → I_COMMIT; commit target latched from in_sel. I_COMMIT: copy shadow → active for that store, pulse x_commit or w_commit, wr_ptr ← 0, return to I_ACCEPT. in_valid ignored in I_COMMIT.
- Shadow X may be reloaded while x_active is consumed; x_active changes only on commit.
- Output FSM: O_IDLE, O_SEND. O_IDLE && res_valid → latch res_data into res_buf, beat_cnt ← 0, pulse res_ack, → O_SEND. O_SEND: out_data = words [beat_cnt*LANES +: LANES], words ≥ OUT_WORDS read as 0. On out_valid && out_ready: beat_cnt++; on last beat (beat_cnt = ceil(OUT_WORDS/LANES)-1) → O_IDLE. res_valid ignored in O_SEND.
- out_data stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready 0, x_active 0, w_active 0, x_commit 0, w_commit 0, in_ovf 0, res_ack 0, out_valid 0, out_data 0, out_last 0; shadow stores, wr_ptr, beat_cnt cleared. in_ready rises first cycle after rst deasserts.
- Beat with in_last accepted at edge N: active store and commit pulse visible cycle N+1 (includes that beat); in_ready low in N+1, high N+2.
- res_valid sampled at edge N in O_IDLE: res_ack and out_valid high in cycle N+1 with beat 0.
- Last beat accepted at edge M: out_valid low in M+1; next capture no earlier than edge M+1 (one-cycle bubble).
- Reset mid-load or mid-send aborts; no partial commit, no res_ack.

## Structure
- Package vit_io_pkg: sel_e (SEL_W=0, SEL_X=1), in_state_e, out_state_e, ceil_div function.
- One sub-module: vit_lane_serializer (res_buf, beat_cnt, output FSM, padding); input side lives in vit_io_stager.

## Test plan
- LANES=2, X_WORDS=8: addr_set 0, 4 X beats (last on 4th) words 1..8 → x_commit at +1, x_active words = 1..8, in_ready low one cycle.
- Load X 0..7, then reload shadow with 9s without in_last → x_active still 0..7; in_last beat → all 9s.
- W load, addr_set 62 with W_WORDS=64, one beat then another → words 62,63 written, second beat dropped, in_ovf=1; next in_addr_set clears it.
- OUT_WORDS=5, LANES=2, res_data words 1..5 → 3 beats {1,2},{3,4},{5,0}, out_last on 3rd, res_ack single pulse.
- out_ready toggling 1,0,0,1 during send → out_data held across stalls, no beat lost or duplicated.
- rst asserted during O_SEND and mid-load → all outputs reset next cycle, no commit pulse.

Source files
------------

// File: rtl/vit_io_pkg.sv
// Shared types and helpers for the ViT host staging block.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package vit_io_pkg;

    typedef enum logic {
        SEL_W = 1'b0,
        SEL_X = 1'b1
    } sel_e;

    typedef enum logic {
        I_ACCEPT = 1'b0,
        I_COMMIT = 1'b1
    } in_state_e;

    typedef enum logic {
        O_IDLE = 1'b0,
        O_SEND = 1'b1
    } out_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/vit_lane_serializer.sv
// Captures one FF result vector and streams it to the host LANES words per beat.
// Latency: res_valid sampled in idle -> beat 0 and res_ack the next cycle; one idle bubble after the last beat.
// Backpressure: out_data/out_last held while out_valid && !out_ready; res_valid ignored while sending.
module vit_lane_serializer
    import vit_io_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 2,
    parameter int OUT_WORDS  = 768
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          res_valid,
    input  logic [OUT_WORDS*DATA_WIDTH-1:0] res_data,
    output logic                          res_ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_last
);

    localparam int NBEATS = ceil_div(OUT_WORDS, LANES);
    localparam int BEAT_W = $clog2(NBEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    out_state_e                      out_state;
    logic [OUT_WORDS*DATA_WIDTH-1:0] res_buf;
    logic [BEAT_W-1:0]               beat_cnt;

    // Words past the end of the result vector pad the final beat with zeros.
    function automatic logic [LANES*DATA_WIDTH-1:0] pick_beat(
        input logic [OUT_WORDS*DATA_WIDTH-1:0] v,
        input int                              beat
    );
        logic [LANES*DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (beat * LANES + k < OUT_WORDS) begin
                r[k*DATA_WIDTH +: DATA_WIDTH] = v[(beat*LANES + k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    // Output FSM: capture in idle, then advance one beat per accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= O_IDLE;
            res_buf   <= '0;
            beat_cnt  <= '0;
            res_ack   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            res_ack <= 1'b0;
            case (out_state)
                O_IDLE: begin
                    if (res_valid) begin
                        res_buf   <= res_data;
                        beat_cnt  <= '0;
                        res_ack   <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= pick_beat(res_data, 0);
                        out_last  <= (NBEATS == 1);
                        out_state <= O_SEND;
                    end
                end
                O_SEND: begin
                    if (out_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            out_state <= O_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                            out_data <= pick_beat(res_buf, int'(beat_cnt) + 1);
                            out_last <= (beat_cnt + BEAT_W'(1) == LAST_BEAT);
                        end
                    end
                end
                default: out_state <= O_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vit_io_stager.sv
// Host staging: multi-lane writes into shadow X/W stores, atomic commit to active stores, result serialiser.
// Latency: in_last beat accepted at edge N -> active store and commit pulse in cycle N+1; in_ready back in N+2.
// Backpressure: in_ready drops for the single commit cycle; output side is valid/ready with held data.
module vit_io_stager
    import vit_io_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 2,
    parameter int X_WORDS    = 768,
    parameter int W_WORDS    = 64,
    parameter int OUT_WORDS  = 768,
    parameter int ADDR_W     = $clog2((X_WORDS > W_WORDS) ? X_WORDS : W_WORDS) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]     in_data,
    input  logic                            in_sel,
    input  logic                            in_addr_set,
    input  logic [ADDR_W-1:0]               in_addr,
    input  logic                            in_last,
    output logic [X_WORDS*DATA_WIDTH-1:0]   x_active,
    output logic [W_WORDS*DATA_WIDTH-1:0]   w_active,
    output logic                            x_commit,
    output logic                            w_commit,
    output logic                            in_ovf,
    input  logic                            res_valid,
    input  logic [OUT_WORDS*DATA_WIDTH-1:0] res_data,
    output logic                            res_ack,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*DATA_WIDTH-1:0]     out_data,
    output logic                            out_last
);

    in_state_e                     in_state;
    logic [ADDR_W-1:0]             wr_ptr;
    logic [ADDR_W-1:0]             base_ptr;
    logic [X_WORDS*DATA_WIDTH-1:0] x_shadow;
    logic [X_WORDS*DATA_WIDTH-1:0] x_nxt;
    logic [W_WORDS*DATA_WIDTH-1:0] w_shadow;
    logic [W_WORDS*DATA_WIDTH-1:0] w_nxt;
    logic                          accept;
    logic                          lane_drop;
    int                            lane_addr;
    sel_e                          beat_sel;

    // in_ready is only ever high in I_ACCEPT, so it doubles as the accept-state qualifier.
    assign accept   = in_valid && in_ready;
    assign beat_sel = sel_e'(in_sel);
    assign base_ptr = in_addr_set ? in_addr : wr_ptr;

    // Merge the current beat into a copy of the shadow stores so a committing beat lands in active directly.
    always_comb begin
        x_nxt     = x_shadow;
        w_nxt     = w_shadow;
        lane_drop = 1'b0;
        lane_addr = 0;
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                lane_addr = int'(base_ptr) + k;
                if (beat_sel == SEL_X) begin
                    if (lane_addr < X_WORDS) begin
                        x_nxt[lane_addr*DATA_WIDTH +: DATA_WIDTH] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        lane_drop = 1'b1;
                    end
                end else begin
                    if (lane_addr < W_WORDS) begin
                        w_nxt[lane_addr*DATA_WIDTH +: DATA_WIDTH] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        lane_drop = 1'b1;
                    end
                end
            end
        end
    end

    // Input FSM: accept beats, commit the selected store on in_last, then hold off one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state <= I_ACCEPT;
            in_ready <= 1'b0;
            wr_ptr   <= '0;
            x_shadow <= '0;
            w_shadow <= '0;
            x_active <= '0;
            w_active <= '0;
            x_commit <= 1'b0;
            w_commit <= 1'b0;
            in_ovf   <= 1'b0;
        end else begin
            x_commit <= 1'b0;
            w_commit <= 1'b0;
            case (in_state)
                I_ACCEPT: begin
                    in_ready <= 1'b1;
                    if (in_ready) begin
                        if (in_addr_set) begin
                            wr_ptr <= in_addr;
                            in_ovf <= lane_drop;
                        end else if (lane_drop) begin
                            in_ovf <= 1'b1;
                        end
                        if (accept) begin
                            x_shadow <= x_nxt;
                            w_shadow <= w_nxt;
                            wr_ptr   <= base_ptr + ADDR_W'(LANES);
                            if (in_last) begin
                                // The commit target is taken from in_sel of the final beat.
                                if (beat_sel == SEL_X) begin
                                    x_active <= x_nxt;
                                    x_commit <= 1'b1;
                                end else begin
                                    w_active <= w_nxt;
                                    w_commit <= 1'b1;
                                end
                                in_ready <= 1'b0;
                                in_state <= I_COMMIT;
                            end
                        end
                    end
                end
                I_COMMIT: begin
                    wr_ptr   <= '0;
                    in_ready <= 1'b1;
                    in_state <= I_ACCEPT;
                end
                default: in_state <= I_ACCEPT;
            endcase
        end
    end

    vit_lane_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .OUT_WORDS  (OUT_WORDS)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ack   (res_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_vit_io_stager.sv
// Bench for vit_io_stager with small stores (X=8, W=64, OUT=5, 2 lanes).
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Expected values come from a word-array model of the staging and serialising rules.
module tb_vit_io_stager;
    localparam int DW = 4;
    localparam int LN = 2;
    localparam int XW = 8;
    localparam int WW = 64;
    localparam int OW = 5;
    localparam int AW = 7;
    localparam int RW = OW * DW;
    localparam int NB = (OW + LN - 1) / LN;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_sel, in_addr_set, in_last;
    logic [LN*DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic [XW*DW-1:0] x_active;
    logic [WW*DW-1:0] w_active;
    logic x_commit, w_commit, in_ovf;
    logic res_valid, res_ack;
    logic [RW-1:0] res_data;
    logic out_valid, out_ready, out_last;
    logic [LN*DW-1:0] out_data;

    int errors = 0;
    int checks = 0;

    int mx_sh[XW], mx_act[XW], mw_sh[WW], mw_act[WW];
    int mptr;
    bit movf;
    int rw[OW];

    always #5 clk = ~clk;

    vit_io_stager #(.DATA_WIDTH(DW), .LANES(LN), .X_WORDS(XW), .W_WORDS(WW), .OUT_WORDS(OW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_addr_set(in_addr_set), .in_addr(in_addr), .in_last(in_last),
        .x_active(x_active), .w_active(w_active), .x_commit(x_commit), .w_commit(w_commit),
        .in_ovf(in_ovf), .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        foreach (mx_sh[i]) begin mx_sh[i] = 0; mx_act[i] = 0; end
        foreach (mw_sh[i]) begin mw_sh[i] = 0; mw_act[i] = 0; end
        mptr = 0;
        movf = 1'b0;
    endtask

    task automatic model_beat(input bit sel, input bit set, input int addr, input logic [LN*DW-1:0] d, input bit last);
        int base;
        bit drop;
        base = set ? addr : mptr;
        drop = 1'b0;
        for (int k = 0; k < LN; k++) begin
            if (sel) begin
                if (base + k < XW) mx_sh[base+k] = int'(d[k*DW +: DW]); else drop = 1'b1;
            end else begin
                if (base + k < WW) mw_sh[base+k] = int'(d[k*DW +: DW]); else drop = 1'b1;
            end
        end
        if (set) movf = 1'b0;
        if (drop) movf = 1'b1;
        mptr = (base + LN) % (1 << AW);
        if (last) begin
            if (sel) mx_act = mx_sh; else mw_act = mw_sh;
            mptr = 0;
        end
    endtask

    function automatic logic [XW*DW-1:0] exp_x();
        logic [XW*DW-1:0] r;
        for (int k = 0; k < XW; k++) r[k*DW +: DW] = DW'(mx_act[k]);
        return r;
    endfunction

    function automatic logic [WW*DW-1:0] exp_w();
        logic [WW*DW-1:0] r;
        for (int k = 0; k < WW; k++) r[k*DW +: DW] = DW'(mw_act[k]);
        return r;
    endfunction

    function automatic logic [LN*DW-1:0] exp_beat(input int b);
        logic [LN*DW-1:0] r;
        r = '0;
        for (int k = 0; k < LN; k++) if (b * LN + k < OW) r[k*DW +: DW] = DW'(rw[b*LN + k]);
        return r;
    endfunction

    function automatic logic [RW-1:0] pack_rw();
        logic [RW-1:0] r;
        for (int k = 0; k < OW; k++) r[k*DW +: DW] = DW'(rw[k]);
        return r;
    endfunction

    // Waits (bounded) for in_ready, presents one beat for one rising edge, updates the model.
    task automatic send_beat(input bit sel, input bit set, input int addr, input logic [LN*DW-1:0] d, input bit last);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_wait got %b want 1", in_ready); end
        in_valid = 1'b1; in_sel = sel; in_addr_set = set; in_addr = AW'(addr); in_data = d; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_addr_set = 1'b0; in_last = 1'b0;
        model_beat(sel, set, addr, d, last);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, x_commit, w_commit, in_ovf, res_ack, out_valid, out_last} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000000", {in_ready, x_commit, w_commit, in_ovf, res_ack, out_valid, out_last});
        end
        checks++;
        if (x_active !== '0) begin errors++; $display("FAIL reset_x_active got %h want 0", x_active); end
        checks++;
        if (w_active !== '0) begin errors++; $display("FAIL reset_w_active got %h want 0", w_active); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise got %b want 1", in_ready); end
    endtask

    task automatic test_x_load();
        send_beat(1'b1, 1'b1, 0, 8'h21, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h43, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h65, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h87, 1'b1);
        checks++;
        if ({x_commit, w_commit, in_ready} !== 3'b100) begin
            errors++; $display("FAIL xload_commit_cycle got %b want 100", {x_commit, w_commit, in_ready});
        end
        checks++;
        if (x_active !== exp_x()) begin errors++; $display("FAIL xload_x_active got %h want %h", x_active, exp_x()); end
        @(negedge clk);
        checks++;
        if ({x_commit, in_ready} !== 2'b01) begin errors++; $display("FAIL xload_after_commit got %b want 01", {x_commit, in_ready}); end
    endtask

    task automatic test_x_reload();
        send_beat(1'b1, 1'b1, 0, 8'h10, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h32, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h54, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h76, 1'b1);
        checks++;
        if (x_active !== exp_x()) begin errors++; $display("FAIL reload_first got %h want %h", x_active, exp_x()); end
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b1, 1'b0, 0, 8'h99, 1'b0);
            checks++;
            if ({x_commit, x_active} !== {1'b0, exp_x()}) begin
                errors++; $display("FAIL reload_shadow_only got %b/%h want 0/%h", x_commit, x_active, exp_x());
            end
        end
        send_beat(1'b1, 1'b1, 0, 8'h99, 1'b1);
        checks++;
        if ({x_commit, x_active} !== {1'b1, exp_x()}) begin
            errors++; $display("FAIL reload_commit got %b/%h want 1/%h", x_commit, x_active, exp_x());
        end
    endtask

    task automatic test_w_ovf();
        send_beat(1'b0, 1'b1, 62, 8'hBA, 1'b0);
        checks++;
        if (in_ovf !== movf) begin errors++; $display("FAIL wovf_in_range got %b want %b", in_ovf, movf); end
        send_beat(1'b0, 1'b0, 0, 8'hDC, 1'b0);
        checks++;
        if (in_ovf !== movf) begin errors++; $display("FAIL wovf_dropped got %b want %b", in_ovf, movf); end
        in_addr_set = 1'b1; in_addr = AW'(5);
        @(negedge clk);
        in_addr_set = 1'b0;
        mptr = 5; movf = 1'b0;
        checks++;
        if (in_ovf !== movf) begin errors++; $display("FAIL wovf_clear got %b want %b", in_ovf, movf); end
        send_beat(1'b0, 1'b1, 63, 8'hFE, 1'b0);
        checks++;
        if (in_ovf !== movf) begin errors++; $display("FAIL wovf_set_wins got %b want %b", in_ovf, movf); end
        send_beat(1'b0, 1'b1, 0, 8'h21, 1'b1);
        checks++;
        if ({x_commit, w_commit, in_ovf} !== {2'b01, movf}) begin
            errors++; $display("FAIL wovf_commit_flags got %b want 01%b", {x_commit, w_commit, in_ovf}, movf);
        end
        checks++;
        if (w_active !== exp_w()) begin errors++; $display("FAIL wovf_w_active got %h want %h", w_active, exp_w()); end
    endtask

    task automatic test_random();
        bit sel, set, last;
        int addr;
        logic [LN*DW-1:0] d;
        for (int i = 0; i < 40; i++) begin
            sel  = 1'($urandom_range(0, 1));
            set  = ($urandom_range(0, 3) == 0);
            addr = sel ? int'($urandom_range(0, 11)) : int'($urandom_range(56, 69));
            d    = (LN*DW)'($urandom);
            last = ($urandom_range(0, 4) == 0);
            send_beat(sel, set, addr, d, last);
            checks++;
            if ({x_active, w_active} !== {exp_x(), exp_w()}) begin
                errors++; $display("FAIL rand_active[%0d] got %h/%h want %h/%h", i, x_active, w_active, exp_x(), exp_w());
            end
            checks++;
            if ({x_commit, w_commit, in_ovf} !== {last && sel, last && !sel, movf}) begin
                errors++; $display("FAIL rand_flags[%0d] got %b want %b", i, {x_commit, w_commit, in_ovf}, {last && sel, last && !sel, movf});
            end
        end
    endtask

    task automatic test_output();
        for (int k = 0; k < OW; k++) rw[k] = k + 1;
        out_ready = 1'b1;
        res_data = pack_rw();
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            checks++;
            if ({out_valid, out_last, res_ack, out_data} !== {1'b1, b == NB - 1, b == 0, exp_beat(b)}) begin
                errors++; $display("FAIL out_beat[%0d] got v%b l%b a%b %h want v1 l%b a%b %h",
                    b, out_valid, out_last, res_ack, out_data, b == NB - 1, b == 0, exp_beat(b));
            end
            @(negedge clk);
        end
        checks++;
        if ({out_valid, res_ack} !== 2'b00) begin errors++; $display("FAIL out_done got %b want 00", {out_valid, res_ack}); end
    endtask

    task automatic test_stall();
        int pat[4] = '{1, 0, 0, 1};
        int eb, cyc;
        bit rdy, keep_v;
        for (int rep = 0; rep < 3; rep++) begin
            keep_v = (rep == 1);
            for (int k = 0; k < OW; k++) rw[k] = int'($urandom_range(0, 15));
            res_data = pack_rw();
            out_ready = 1'b0;
            res_valid = 1'b1;
            @(negedge clk);
            if (keep_v) res_data = RW'($urandom); else res_valid = 1'b0;
            eb = 0;
            cyc = 0;
            while (eb < NB && cyc < 40) begin
                checks++;
                if ({out_valid, out_last, res_ack, out_data} !== {1'b1, eb == NB - 1, cyc == 0, exp_beat(eb)}) begin
                    errors++; $display("FAIL stall_beat[%0d/%0d] got v%b l%b a%b %h want v1 l%b a%b %h",
                        rep, cyc, out_valid, out_last, res_ack, out_data, eb == NB - 1, cyc == 0, exp_beat(eb));
                end
                rdy = (rep == 0 && cyc < 4) ? (pat[cyc] != 0) : 1'($urandom_range(0, 1));
                out_ready = rdy;
                @(negedge clk);
                if (rdy) eb++;
                cyc++;
            end
            if (eb != NB) begin
                checks++; errors++; $display("FAIL stall_timeout[%0d] got %0d beats want %0d", rep, eb, NB);
            end
            checks++;
            if ({out_valid, res_ack} !== 2'b00) begin errors++; $display("FAIL stall_bubble[%0d] got %b want 00", rep, {out_valid, res_ack}); end
            res_valid = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < OW; k++) rw[k] = 9;
        res_data = pack_rw();
        out_ready = 1'b0;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_send_started got %b want 1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, res_ack, out_data} !== '0) begin
            errors++; $display("FAIL abort_send got %b %h want 000 00", {out_valid, out_last, res_ack}, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        checks++;
        if ({out_valid, res_ack} !== 2'b00) begin errors++; $display("FAIL abort_no_resend got %b want 00", {out_valid, res_ack}); end
        send_beat(1'b1, 1'b1, 0, 8'h55, 1'b0);
        send_beat(1'b1, 1'b0, 0, 8'h66, 1'b0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h77; in_last = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({x_commit, w_commit, in_ready, in_ovf} !== 4'b0) begin
            errors++; $display("FAIL abort_load_flags got %b want 0000", {x_commit, w_commit, in_ready, in_ovf});
        end
        checks++;
        if (x_active !== '0) begin errors++; $display("FAIL abort_load_x_active got %h want 0", x_active); end
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        send_beat(1'b1, 1'b0, 0, 8'h31, 1'b1);
        checks++;
        if ({x_commit, x_active} !== {1'b1, exp_x()}) begin
            errors++; $display("FAIL abort_shadow_cleared got %b/%h want 1/%h", x_commit, x_active, exp_x());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_addr_set = 1'b0; in_addr = '0;
        in_data = '0; in_last = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
        test_reset();
        test_x_load();
        test_x_reload();
        test_w_ovf();
        test_random();
        test_output();
        test_stall();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
